// File: rtl/router_pkg.sv
// Shared router types and constants: flit type encoding, port indices and the
// arbiter state encoding used by the per-output controllers.
package router_pkg;

    localparam int NUM_PORTS = 5;
    localparam int DATA_W    = 16;

    localparam int PORT_N = 0;
    localparam int PORT_E = 1;
    localparam int PORT_S = 2;
    localparam int PORT_W = 3;
    localparam int PORT_L = 4;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_TAIL   = 2'b01,
        FLIT_HEAD   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Takes the two type bits from the top of a flit.
    function automatic flit_type_t get_flit_type(input logic [1:0] type_bits);
        return flit_type_t'(type_bits);
    endfunction

endpackage

// File: rtl/rr_grant_select.sv
// Combinational round-robin pick: first set request bit at or above the one-hot
// pointer, wrapping from the top index back to bit 0. Grant is zero if no request.
module rr_grant_select #(
    parameter int N = 5
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] grant
);

    logic [2*N-1:0] w_req_dbl;
    logic [2*N-1:0] w_diff;
    logic [2*N-1:0] w_grant_dbl;

    // Subtracting the pointer from the doubled request vector borrows through the
    // cleared bits below the winner, so AND-NOT isolates it; folding halves wraps.
    assign w_req_dbl   = {req, req};
    assign w_diff      = w_req_dbl - {{N{1'b0}}, ptr};
    assign w_grant_dbl = w_req_dbl & ~w_diff;
    assign grant       = w_grant_dbl[N-1:0] | w_grant_dbl[2*N-1:N];

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output-port controller: round-robin input selection, packet lock from HEAD
// to TAIL, downstream credit gating and a registered flit/valid output.
module output_port_arbiter #(
    parameter int NUM_IN     = 5,
    parameter int DATA_W     = 16,
    parameter int CREDIT_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN-1:0]        req_i,
    input  logic [NUM_IN*DATA_W-1:0] flit_i,
    input  logic                     credit_i,
    output logic [NUM_IN-1:0]        pop_o,
    output logic [DATA_W-1:0]        data_o,
    output logic                     valid_o,
    output logic                     locked_o,
    output logic [CNT_W-1:0]         credit_cnt_o,
    output logic                     err_o
);
    import router_pkg::*;

    localparam logic [CNT_W:0] MAX_EXT = (CNT_W+1)'(CREDIT_MAX);

    arb_state_t          r_state, w_state_next;
    logic [NUM_IN-1:0]   r_owner, w_owner_next;
    logic [NUM_IN-1:0]   r_ptr, w_ptr_next;
    logic [CNT_W-1:0]    r_credit_cnt, w_credit_next;
    logic [DATA_W-1:0]   r_data;
    logic                r_valid;
    logic                r_err, w_err_next;

    logic [NUM_IN-1:0]   w_cand, w_grant, w_grant_rot;
    logic                w_send, w_credit_ovf;
    logic [CNT_W:0]      w_cnt_sum;
    logic [DATA_W-1:0]   w_masked [NUM_IN];
    logic [DATA_W-1:0]   w_win_flit;
    flit_type_t          w_win_type;

    // While locked only the owner is a candidate, so the grant is the owner itself.
    assign w_cand = (r_state == ST_LOCKED) ? (req_i & r_owner) : req_i;

    rr_grant_select #(.N(NUM_IN)) u_rr_grant_select (
        .req   (w_cand),
        .ptr   (r_ptr),
        .grant (w_grant)
    );

    assign w_send      = (|w_cand) && (r_credit_cnt != '0);
    assign pop_o       = (w_send && !reset) ? w_grant : '0;
    assign w_grant_rot = {w_grant[NUM_IN-2:0], w_grant[NUM_IN-1]};

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_flit_mask
            assign w_masked[gi] = flit_i[gi*DATA_W +: DATA_W] & {DATA_W{w_grant[gi]}};
        end
    endgenerate

    always_comb begin
        w_win_flit = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_win_flit = w_win_flit | w_masked[k];
        end
    end

    assign w_win_type = get_flit_type(w_win_flit[DATA_W-1 -: 2]);

    // A credit with every downstream slot already free is a protocol error; clamp it.
    assign w_cnt_sum     = {1'b0, r_credit_cnt} - {{CNT_W{1'b0}}, w_send}
                         + {{CNT_W{1'b0}}, credit_i};
    assign w_credit_ovf  = (w_cnt_sum > MAX_EXT);
    assign w_credit_next = w_credit_ovf ? MAX_EXT[CNT_W-1:0] : w_cnt_sum[CNT_W-1:0];

    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_ptr_next   = r_ptr;
        w_err_next   = r_err | w_credit_ovf;
        if (w_send) begin
            if (r_state == ST_IDLE) begin
                w_ptr_next = w_grant_rot;
                if (w_win_type == FLIT_HEAD) begin
                    w_state_next = ST_LOCKED;
                    w_owner_next = w_grant;
                end else if (w_win_type == FLIT_BODY || w_win_type == FLIT_TAIL) begin
                    w_err_next = 1'b1;
                end
            end else begin
                if (w_win_type == FLIT_TAIL) begin
                    w_state_next = ST_IDLE;
                    w_owner_next = '0;
                end else if (w_win_type == FLIT_HEAD || w_win_type == FLIT_SINGLE) begin
                    w_err_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_ptr        <= {{(NUM_IN-1){1'b0}}, 1'b1};
            r_credit_cnt <= CNT_W'(CREDIT_MAX);
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_ptr        <= w_ptr_next;
            r_credit_cnt <= w_credit_next;
            r_valid      <= w_send;
            r_err        <= w_err_next;
            if (w_send) begin
                r_data <= w_win_flit;
            end
        end
    end

    assign data_o       = r_data;
    assign valid_o      = r_valid;
    assign locked_o     = (r_state == ST_LOCKED);
    assign credit_cnt_o = r_credit_cnt;
    assign err_o        = r_err;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Scoreboard bench for output_port_arbiter: directed scenarios plus random traffic
// checked against an index-based behavioural model of the arbitration rules.
module tb_output_port_arbiter;

    localparam int N  = 5;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_i;
    logic [N*DW-1:0] flit_i;
    logic            credit_i;
    logic [N-1:0]    pop_o;
    logic [DW-1:0]   data_o;
    logic            valid_o;
    logic            locked_o;
    logic [2:0]      credit_cnt_o;
    logic            err_o;

    output_port_arbiter #(
        .NUM_IN(N), .DATA_W(DW), .CREDIT_MAX(4), .CNT_W(3)
    ) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .flit_i(flit_i),
        .credit_i(credit_i), .pop_o(pop_o), .data_o(data_o), .valid_o(valid_o),
        .locked_o(locked_o), .credit_cnt_o(credit_cnt_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: owner index (-1 = none), pointer index, credit count, error.
    int          m_owner;
    int          m_ptr;
    int          m_cnt;
    bit          m_err;
    logic [15:0] exp_q[$];
    logic [15:0] m_last;
    bit          mon_en = 1'b0;
    logic [15:0] mon_f;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk(input logic [1:0] t, input logic [13:0] p);
        return {t, p};
    endfunction

    function automatic logic [N*DW-1:0] all_flits(input logic [1:0] t, input logic [7:0] tag);
        logic [N*DW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = mk(t, {tag, 6'(k)});
        return v;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 4;
        m_err   = 1'b0;
        m_last  = '0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        req_i    = 5'b11111;
        flit_i   = all_flits(2'b11, 8'hEE);
        credit_i = 1'b0;
        #1;
        check("rst_pop", pop_o, 0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_cnt", credit_cnt_o, 4);
        check("rst_locked", locked_o, 0);
        check("rst_err", err_o, 0);
        mon_en = 1'b1;
        $display("reset applied: cnt=%0d locked=%0b err=%0b", credit_cnt_o, locked_o, err_o);
    endtask

    // One arbitration cycle: drive inputs, predict the grant, then check state.
    task automatic cycle(input logic [N-1:0] req, input logic [N*DW-1:0] flits, input logic cr);
        int          win;
        bit          send;
        logic [15:0] f;
        logic [1:0]  t;
        logic [N-1:0] exp_pop;
        @(negedge clk);
        reset    = 1'b0;
        req_i    = req;
        flit_i   = flits;
        credit_i = cr;
        #1;
        win = -1;
        for (int o = 0; o < N; o++) begin
            int k;
            k = (m_ptr + o) % N;
            if (win < 0 && req[k] && (m_owner < 0 || k == m_owner)) win = k;
        end
        send    = (win >= 0) && (m_cnt > 0);
        exp_pop = send ? N'(1 << win) : '0;
        check("pop", pop_o, exp_pop);
        if (send) begin
            f = flits[win*DW +: DW];
            exp_q.push_back(f);
            t = f[15:14];
            if (m_owner < 0) begin
                m_ptr = (win + 1) % N;
                if (t == 2'b10) m_owner = win;
                else if (t == 2'b00 || t == 2'b01) m_err = 1'b1;
            end else begin
                if (t == 2'b01) m_owner = -1;
                else if (t[1]) m_err = 1'b1;
            end
        end
        m_cnt = m_cnt - (send ? 1 : 0) + (cr ? 1 : 0);
        if (m_cnt > 4) begin
            m_cnt = 4;
            m_err = 1'b1;
        end
        @(posedge clk);
        #1;
        check("credit_cnt", credit_cnt_o, m_cnt);
        check("locked", locked_o, (m_owner >= 0));
        check("err", err_o, m_err);
        $display("req=%05b cr=%0b pop=%05b cnt=%0d locked=%0b err=%0b",
                 req, cr, pop_o, credit_cnt_o, locked_o, err_o);
    endtask

    // Monitor: every registered output is matched against the scoreboard queue.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                if (valid_o) begin
                    if (exp_q.size() == 0) begin
                        check("valid_extra", valid_o, 0);
                    end else begin
                        mon_f = exp_q.pop_front();
                        check("data", data_o, mon_f);
                        m_last = mon_f;
                    end
                end else begin
                    check("data_hold", data_o, m_last);
                    if (exp_q.size() != 0) begin
                        check("valid_missing", valid_o, 1);
                        exp_q.delete();
                    end
                end
            end
        end
    end

    initial begin
        logic [N*DW-1:0] fl;
        logic [1:0]      pkt [3];
        reset    = 1'b1;
        req_i    = '0;
        flit_i   = '0;
        credit_i = 1'b0;
        pkt[0] = 2'b10;
        pkt[1] = 2'b00;
        pkt[2] = 2'b01;

        do_reset();

        // Fairness: all inputs request SINGLE flits with credit returned each cycle.
        for (int i = 0; i < 5; i++) cycle(5'b11111, all_flits(2'b11, 8'(i)), 1'b1);

        // Move the pointer to E, then E sends a 3-flit packet while N and L request.
        cycle(5'b00001, all_flits(2'b11, 8'h08), 1'b1);
        for (int i = 0; i < 3; i++) begin
            fl = all_flits(2'b11, 8'(8'h10 + i));
            fl[1*DW +: DW] = mk(pkt[i], 14'(14'h100 + i));
            cycle(5'b10011, fl, 1'b1);
        end
        cycle(5'b10101, all_flits(2'b11, 8'h20), 1'b1);
        cycle(5'b10001, all_flits(2'b11, 8'h21), 1'b1);

        // Credits: exhaust, stall, single credit, then simultaneous send and credit.
        for (int i = 0; i < 6; i++) cycle(5'b00001, all_flits(2'b11, 8'(8'h30 + i)), 1'b0);
        cycle(5'b00001, all_flits(2'b11, 8'h40), 1'b1);
        cycle(5'b00001, all_flits(2'b11, 8'h41), 1'b1);
        cycle(5'b00001, all_flits(2'b11, 8'h42), 1'b0);
        cycle(5'b00001, all_flits(2'b11, 8'h43), 1'b0);

        // Credit with the counter already full.
        do_reset();
        cycle(5'b00000, all_flits(2'b11, 8'h50), 1'b1);
        cycle(5'b00000, all_flits(2'b11, 8'h51), 1'b0);

        // BODY flit while idle is forwarded and the error sticks.
        do_reset();
        cycle(5'b00100, all_flits(2'b00, 8'h60), 1'b0);
        cycle(5'b00000, all_flits(2'b11, 8'h61), 1'b0);
        cycle(5'b00010, all_flits(2'b11, 8'h62), 1'b0);

        // Reset in the middle of W's packet, then N is granted straight away.
        do_reset();
        cycle(5'b01000, all_flits(2'b10, 8'h70), 1'b0);
        cycle(5'b01001, all_flits(2'b00, 8'h71), 1'b0);
        do_reset();
        cycle(5'b01001, all_flits(2'b11, 8'h72), 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 99) do_reset();
            fl = {$urandom, $urandom, $urandom};
            cycle(N'($urandom_range(0, 31)), fl, ($urandom_range(0, 2) == 0));
        end

        cycle(5'b00000, all_flits(2'b11, 8'hFF), 1'b0);
        @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- Per-output-port controller for the 5-port mesh router crossbar. One instance drives each output: N, E, S, W and L.
- Takes route-computed requests from the five input buffers and selects one input round-robin.
- Locks that input for the whole multi-flit packet, gates every send on downstream credits, and drives the registered output flit/valid pair.
- Pops the winning input buffer with a one-hot pop.

Parameters:
- NUM_IN, 5, number of requesting inputs (bit order N=0, E=1, S=2, W=3, L=4).
- DATA_W, 16, flit width; flit type in bits [DATA_W-1:DATA_W-2].
- CREDIT_MAX, 4, downstream buffer depth; reset value of the credit counter.
- CNT_W, 3, credit counter width; must satisfy CNT_W >= clog2(CREDIT_MAX+1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_i  input  NUM_IN  per-input request; input's head-of-queue flit targets this output.
- flit_i  input  NUM_IN*DATA_W  head-of-queue flits, input k at [k*DATA_W +: DATA_W].
- credit_i  input  1  one-cycle pulse; downstream freed one slot.
- pop_o  output  NUM_IN  one-hot, combinational; input k dequeues its flit this cycle.
- data_o  output  DATA_W  registered outgoing flit.
- valid_o  output  1  registered; data_o valid this cycle.
- locked_o  output  1  state == LOCKED.
- credit_cnt_o  output  CNT_W  current credit count.
- err_o  output  1  sticky protocol-error flag.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. All state updates on the rising edge of clk.
- Flit types (bits [15:14]):
  - 2'b10 HEAD
  - 2'b00 BODY
  - 2'b01 TAIL
  - 2'b11 SINGLE
- Reset values:
  - state = IDLE, owner = 0, ptr = 5'b00001.
  - credit_cnt = CREDIT_MAX.
  - valid_o = 0, data_o = 0, err_o = 0.
  - pop_o = 0 while reset is asserted.
- Candidate set:
  - IDLE: req_i.
  - LOCKED: req_i & owner.
- Winner: first set candidate bit scanning cyclically from ptr upward (wrapping L to N).
- send = (candidate set != 0) && (credit_cnt != 0).
- pop_o = winner one-hot when send, else 0. Combinational from req_i, state and credit_cnt.
- Output register (latency 1 from pop to valid_o):
  - On send: valid_o <= 1 and data_o <= flit_i of the winner.
  - Otherwise: valid_o <= 0 and data_o holds its last value.
- IDLE transitions:
  - Send of HEAD: state <= LOCKED, owner <= winner, ptr <= winner rotated left by 1 (wrapping L to N).
  - Send of SINGLE: stay IDLE; ptr <= winner rotated left by 1.
  - Send of BODY or TAIL: err_o <= 1; forward as SINGLE (stay IDLE, ptr updated).
- LOCKED transitions:
  - Only owner may send; requests from all other inputs are ignored.
  - Send of TAIL: state <= IDLE, owner <= 0.
  - Send of BODY: stay LOCKED.
  - Send of HEAD or SINGLE: err_o <= 1; stay LOCKED (treated as BODY).
  - Owner not requesting: stall in LOCKED indefinitely; no timeout.
- Credits:
  - credit_cnt_next = credit_cnt - send + credit_i.
  - Send and credit_i in the same cycle leave the count unchanged.
  - credit_i at credit_cnt == CREDIT_MAX: count saturates and err_o <= 1.
  - A credit arriving at count 0 does not enable a send until the next cycle.
  - The count never underflows.
- err_o is cleared only by reset.
- Reset mid-packet: all state returns to reset values and the partial packet is abandoned. Recovery is the input buffers' responsibility.

Decomposition:
- router_pkg holds:
  - typedef flit_type_t with FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE.
  - Constants NUM_PORTS=5, DATA_W=16, PORT_N/E/S/W/L indices.
  - Function get_flit_type().
- One sub-module, rr_grant_select: combinational; inputs req and ptr (one-hot), output grant (one-hot or zero). Reused by future VC allocators.
- State register, owner, credit counter and output register stay in output_port_arbiter.

Test Plan:
- Fairness: after reset, req_i=5'b11111 for 5 cycles, all SINGLE flits, credits returned each cycle. pop_o must be 00001, 00010, 00100, 01000, 10000; valid_o high each following cycle with matching data_o.
- Lock: input E sends HEAD, BODY, TAIL while N and L request continuously. pop_o = 00010 for 3 consecutive cycles, locked_o=1 for 2 of them. Next grant is S if requesting, else W, else L, else N (ptr=00100).
- Credits: no credit_i, 6 SINGLE requests from N. Exactly 4 pops, then credit_cnt_o=0 and pop_o=0. One credit_i pulse gives exactly one more pop on the following cycle. Simultaneous send+credit_i holds the count.
- Protocol errors:
  - BODY flit arriving while IDLE: forwarded, state stays IDLE, err_o=1 sticky.
  - credit_i at count 4: count stays 4, err_o=1.
- Reset mid-packet: assert reset after W's HEAD while LOCKED. Next cycle state IDLE, ptr=00001, credit_cnt_o=4, valid_o=0, err_o=0; a subsequent N request is granted immediately.
